// File: rtl/pkg_matriz.sv
// Shared constants and FSM encoding for the scalar-by-matrix controllers.
// Sibling matrix controllers import this package so they agree on geometry.
package pkg_matriz;

   localparam int MAT_DIM = 5;
   localparam int MAT_W   = 8;
   localparam int MAT_N   = MAT_DIM * MAT_DIM;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIM  = 2'd2
   } estado_t;

endpackage

// File: rtl/mult_elemento.sv
// One signed W x W multiply step: truncated W-bit product plus a flag that
// is set when the full product does not fit in signed W bits.
module mult_elemento
   import pkg_matriz::*;
#(
   parameter int W = MAT_W
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic        [W-1:0] produto,
   output logic                overflow
);

   logic signed [2*W-1:0] cheio;

   always_comb begin
      cheio    = a * b;
      produto  = cheio[W-1:0];
      // The product fits only if the top W+1 bits are all copies of the sign.
      overflow = (cheio[2*W-1:W-1] != {(W+1){cheio[W-1]}});
   end

endmodule

// File: rtl/controle_mult_escalar.sv
// Multiplies a captured DIM x DIM signed matrix by a captured signed scalar,
// one element per cycle through a single shared multiplier.
module controle_mult_escalar
   import pkg_matriz::*;
#(
   parameter int DIM = MAT_DIM,
   parameter int W   = MAT_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [DIM*DIM*W-1:0]    matriz_A,
   input  logic signed [W-1:0]     num_inteiro,
   output logic                    busy,
   output logic                    done,
   output logic [DIM*DIM*W-1:0]    nova_matriz_A,
   output logic                    overflow
);

   localparam int N  = DIM * DIM;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   estado_t              estado;
   logic [IW-1:0]        idx;
   logic [N*W-1:0]       cap_a;
   logic signed [W-1:0]  cap_s;
   logic signed [W-1:0]  elem_a;
   logic [W-1:0]         prod;
   logic                 prod_ovf;

   // idx stays in 0..N-1 in every state, so this select never leaves cap_a.
   assign elem_a = cap_a[idx*W +: W];

   mult_elemento #(.W(W)) u_mult (
      .a        (elem_a),
      .b        (cap_s),
      .produto  (prod),
      .overflow (prod_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado        <= IDLE;
         idx           <= '0;
         cap_a         <= '0;
         cap_s         <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         overflow      <= 1'b0;
         nova_matriz_A <= '0;
      end else begin
         case (estado)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  cap_a         <= matriz_A;
                  cap_s         <= num_inteiro;
                  nova_matriz_A <= '0;
                  overflow      <= 1'b0;
                  idx           <= '0;
                  busy          <= 1'b1;
                  estado        <= RUN;
               end
            end
            RUN: begin
               nova_matriz_A[idx*W +: W] <= prod;
               if (prod_ovf) begin
                  overflow <= 1'b1;
               end
               if (idx == IW'(N - 1)) begin
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  estado <= FIM;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            FIM: begin
               // A start seen on this edge is dropped on purpose.
               done   <= 1'b0;
               estado <= IDLE;
            end
            default: begin
               busy   <= 1'b0;
               done   <= 1'b0;
               estado <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_controle_mult_escalar.sv
// Directed bench for controle_mult_escalar: the driver pushes hand-computed
// results into a queue and a monitor compares them whenever done pulses.
module tb_controle_mult_escalar;

   localparam int W  = 8;
   localparam int N  = 25;
   localparam int MW = N * W;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic                 start = 1'b0;
   logic [MW-1:0]        matriz_A = '0;
   logic signed [W-1:0]  num_inteiro = '0;
   logic                 busy;
   logic                 done;
   logic [MW-1:0]        nova_matriz_A;
   logic                 overflow;

   int checks = 0;
   int errors = 0;
   int busy_cnt = 0;
   logic [MW:0] exp_q[$];

   controle_mult_escalar dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .matriz_A      (matriz_A),
      .num_inteiro   (num_inteiro),
      .busy          (busy),
      .done          (done),
      .nova_matriz_A (nova_matriz_A),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string nome, input logic [MW:0] atual, input logic [MW:0] esperado);
      checks++;
      if (atual !== esperado) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nome, atual, esperado);
      end
   endtask

   function automatic logic [MW-1:0] preenche(input logic [W-1:0] v);
      logic [MW-1:0] m;
      for (int k = 0; k < N; k++) m[k*W +: W] = v;
      return m;
   endfunction

   // Element k = mult*(k+1), truncated to W bits.
   function automatic logic [MW-1:0] sequencia(input int mult);
      logic [MW-1:0] m;
      for (int k = 0; k < N; k++) m[k*W +: W] = W'(mult * (k + 1));
      return m;
   endfunction

   // Monitor: pops the expected result on every done pulse.
   initial begin
      logic [MW:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_cnt = 0;
         end else begin
            if (busy) busy_cnt++;
            if (done) begin
               check("busy_ciclos", busy_cnt, 25);
               check("busy_em_done", busy, 0);
               busy_cnt = 0;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL done_inesperado: got done=1 expected no pending result");
               end else begin
                  e = exp_q.pop_front();
                  check("matriz", nova_matriz_A, e[MW-1:0]);
                  check("overflow", overflow, e[MW]);
               end
            end
         end
      end
   end

   // Issues one operation, optionally disturbing the inputs while it runs,
   // then watches a fixed window for latency and the number of done pulses.
   task automatic run_op(input logic [MW-1:0] a, input logic signed [W-1:0] s,
                         input logic [MW-1:0] exp_m, input logic exp_o, input bit perturba);
      int lat = 0;
      int nd  = 0;
      @(negedge clk);
      matriz_A    = a;
      num_inteiro = s;
      start       = 1'b1;
      exp_q.push_back({exp_o, exp_m});
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (perturba && (c == 5 || c == 25 || c == 26)) begin
            start       = 1'b1;
            matriz_A    = ~a;
            num_inteiro = s + 8'sd1;
         end
         if (done) begin
            nd++;
            if (lat == 0) lat = c;
         end
      end
      start = 1'b0;
      check("latencia_done", lat, 26);
      check("pulsos_done", nd, 1);
   endtask

   initial begin
      logic [MW-1:0] m;
      int nd;

      // Reset before any clock edge
      #1 rst_n = 1'b0;
      #1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_overflow", overflow, 0);
      check("reset_matriz", nova_matriz_A, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(sequencia(1), 8'sd3, sequencia(3), 1'b0, 1'b0);
      run_op(sequencia(1), 8'sd2, sequencia(2), 1'b0, 1'b1);
      run_op(preenche(8'd13), 8'sd10, preenche(8'h82), 1'b1, 1'b0);
      run_op(sequencia(1), 8'sd0, '0, 1'b0, 1'b0);

      m = preenche(8'd1);
      m[7:0] = 8'h80;
      run_op(m, -8'sd1, {preenche(8'hFF)} & ~{{(MW-8){1'b0}}, 8'hFF} | {{(MW-8){1'b0}}, 8'h80},
             1'b1, 1'b0);
      run_op(preenche(8'd16), 8'sd8, preenche(8'h80), 1'b1, 1'b0);

      // Abort mid-run: outputs clear without a clock and no done follows
      @(negedge clk);
      matriz_A    = sequencia(1);
      num_inteiro = 8'sd3;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_overflow", overflow, 0);
      check("abort_matriz", nova_matriz_A, 0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("abort_sem_done", nd, 0);

      run_op(sequencia(1), 8'sd3, sequencia(3), 1'b0, 1'b0);

      check("fila_vazia", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/controle_mult_escalar.md
CONTROLE_MULT_ESCALAR -- requirements
Module: controle_mult_escalar

Interface
REQ-001 SHALL have parameter DIM, default 5, matrix dimension; element count is DIM*DIM.
REQ-002 SHALL have parameter W, default 8, element and scalar width in bits (signed).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, request a new scalar-by-matrix operation.
REQ-006 SHALL have port matriz_A, input, DIM*DIM*W (200), signed source matrix; element k at bits [k*W +: W], k=0..24.
REQ-007 SHALL have port num_inteiro, input, W, signed scalar.
REQ-008 SHALL have port busy, output, 1, high while elements are being processed.
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port nova_matriz_A, output, DIM*DIM*W, result matrix, same element packing as matriz_A.
REQ-011 SHALL have port overflow, output, 1, sticky flag: at least one product of the current operation left the signed W-bit range.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIM; reset state IDLE.
REQ-013 IDLE: start=1 at edge k SHALL capture matriz_A and num_inteiro into internal registers, clear nova_matriz_A and overflow to 0, set index to 0, and enter RUN at that edge.
REQ-014 RUN: one element per cycle; at each edge, element[index] SHALL receive the low W bits of the full 2W-bit signed product captured_A[index]*captured_scalar, and index increments.
REQ-015 A product outside [-128, 127] SHALL set overflow at the same edge; overflow stays set until the next accepted start or reset.
REQ-016 After writing index DIM*DIM-1 (edge k+25), FSM SHALL enter FIM; index does not wrap within an operation.
REQ-017 FIM SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 busy SHALL equal 1 exactly while in RUN (edges k+1..k+25 observed); done high for the cycle following edge k+25.
REQ-019 start SHALL be ignored in RUN and FIM; input changes after capture SHALL not affect the running operation.
REQ-020 start in IDLE at the edge FIM->IDLE occurs is not sampled; the earliest accepted restart is one cycle after done.
REQ-021 nova_matriz_A and overflow SHALL hold their final values in IDLE until the next accepted start.
REQ-022 Only one W x W signed multiplier SHALL be instantiated, time-shared over all elements.

Reset
REQ-023 rst_n=0 SHALL immediately, without a clock, force IDLE, index=0, busy=0, done=0, overflow=0, nova_matriz_A=0, and clear captured operands.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release, the next start begins a fresh operation.

Structure
REQ-025 DIM, W, element count (25), and FSM state encodings SHALL live in shared package pkg_matriz for reuse by sibling matrix controllers.
REQ-026 The datapath step SHALL be sub-module mult_elemento: W-bit signed operands in, W-bit truncated product and overflow bit out, purely combinational.
REQ-027 Implementation target: 120-400 lines of RTL.

Verification
REQ-028 matriz_A = 1..25 (element k = k+1), scalar 3, start one cycle -> done 26 cycles after the start edge, element k = 3*(k+1) (last = 75), overflow=0, busy high for exactly 25 cycles.
REQ-029 All elements 13, scalar 10 -> every element 0x82 (-126), overflow=1.
REQ-030 Element 0 = -128, others 1, scalar -1 -> element 0 = -128 (product 128 truncated), others -1, overflow=1.
REQ-031 start pulsed again at cycles 5 and 25 of RUN with different operands -> ignored; result matches the first capture; exactly one done pulse.
REQ-032 rst_n low during RUN cycle 10 -> all outputs 0 asynchronously, no done; then 1..25 x 3 completes as REQ-028.
REQ-033 Scalar 0 after a nonzero run -> all elements 0, overflow cleared to 0.
